seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Generates the digit-select sequence, active-low anode pattern and selected nibble from a 16-bit display word.
- Sits upstream of the nibble-to-segment decoder; accepts new display words from system logic (e.g. temperature sensor path) and applies them only at frame boundaries, so the display never tears.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_refresh_prescaler.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan path: anode patterns,
// slot indices, scan phase encoding and small helpers.
package seg7_pkg;

  // Active-low anode patterns, one digit lit per slot.
  localparam logic [3:0] AN_D0  = 4'b0111;
  localparam logic [3:0] AN_D1  = 4'b1011;
  localparam logic [3:0] AN_D2  = 4'b1101;
  localparam logic [3:0] AN_D3  = 4'b1110;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Slot indices, 0 is the leftmost digit.
  localparam logic [1:0] SLOT_0 = 2'd0;
  localparam logic [1:0] SLOT_1 = 2'd1;
  localparam logic [1:0] SLOT_2 = 2'd2;
  localparam logic [1:0] SLOT_3 = 2'd3;

  // Per-slot phase: anodes dark during GUARD, lit during ON.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  // Prescaler counter width; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Anode pattern that lights the digit for a given slot.
  function automatic logic [3:0] anode_of(input logic [1:0] slot);
    logic [3:0] pat;
    pat = AN_OFF;
    case (slot)
      SLOT_0:  pat = AN_D0;
      SLOT_1:  pat = AN_D1;
      SLOT_2:  pat = AN_D2;
      SLOT_3:  pat = AN_D3;
      default: pat = AN_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_refresh_prescaler.sv
// Free-running slot timer: counts 0..REFRESH_DIV-1 and flags the last
// cycle of each slot. Kept standalone so other scanned displays can reuse it.
module seg7_refresh_prescaler
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [cnt_width(REFRESH_DIV)-1:0] cnt,
  output logic                              slot_end
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign cnt      = cnt_reg;
  assign slot_end = (cnt_reg == CNT_LAST);

  // Wrap the slot counter at the end of each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (slot_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller. Walks the digit slots, inserts a
// dark guard interval at the start of each slot, blanks leading zeros on
// request, and swaps in newly loaded display words only between frames.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        disp_en,
  input  logic        blank_lz,
  output logic [1:0]  sel,
  output logic [3:0]  digit_val,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  // Cycle on which the guard interval ends; only meaningful for a non-zero guard.
  localparam logic [CNT_W-1:0] GUARD_LAST =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
  localparam phase_t PH_SLOT_START = (GUARD_CYCLES > 0) ? PH_GUARD : PH_ON;

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             frame_boundary;

  logic [1:0]  slot_reg;
  phase_t      phase_reg, phase_next;
  logic [15:0] display_reg;
  logic [15:0] pending_reg;
  logic        pend_flag_reg;
  logic        boundary_d_reg;

  logic [3:0]  an_reg, an_next;
  logic [3:0]  digit_reg, digit_next;
  logic [1:0]  sel_reg;
  logic        frame_done_reg;

  logic [3:0]  nib [4];
  logic [3:0]  lead_zero;

  seg7_refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  assign frame_boundary = slot_end && (slot_reg == SLOT_3);

  // Split the display word into per-slot nibbles and build the
  // "this digit and everything left of it is zero" chain.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = display_reg[15 - 4*gi -: 4];
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = (nib[gi] == 4'h0);
      end else begin : g_rest
        assign lead_zero[gi] = lead_zero[gi-1] && (nib[gi] == 4'h0);
      end
    end
  endgenerate

  // Advance the digit slot at the end of every slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_reg <= SLOT_0;
    end else if (slot_end) begin
      slot_reg <= slot_reg + 2'd1;
    end
  end

  // Double buffer: loads park in pending until a frame boundary, except a
  // load landing on the boundary itself, which goes straight to the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_reg   <= '0;
      pending_reg   <= '0;
      pend_flag_reg <= 1'b0;
    end else if (frame_boundary) begin
      if (load) begin
        display_reg   <= data_in;
        pend_flag_reg <= 1'b0;
      end else if (pend_flag_reg) begin
        display_reg   <= pending_reg;
        pend_flag_reg <= 1'b0;
      end
    end else if (load) begin
      pending_reg   <= data_in;
      pend_flag_reg <= 1'b1;
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= PH_SLOT_START;
    end else begin
      phase_reg <= phase_next;
    end
  end

  // Phase next-state and next output values for the registered outputs.
  always_comb begin
    phase_next = phase_reg;
    an_next    = AN_OFF;
    digit_next = nib[slot_reg];

    if (slot_end) begin
      phase_next = PH_SLOT_START;
    end else if ((GUARD_CYCLES > 0) && (cnt == GUARD_LAST)) begin
      phase_next = PH_ON;
    end

    if ((phase_reg == PH_ON) && disp_en &&
        !(blank_lz && (slot_reg != SLOT_3) && lead_zero[slot_reg])) begin
      an_next = anode_of(slot_reg);
    end
  end

  // Output registers; frame_done is delayed twice so it lines up with the
  // first registered output of the newly applied display word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg         <= AN_OFF;
      digit_reg      <= 4'h0;
      sel_reg        <= SLOT_0;
      boundary_d_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      digit_reg      <= digit_next;
      sel_reg        <= slot_reg;
      boundary_d_reg <= frame_boundary;
      frame_done_reg <= boundary_d_reg;
    end
  end

  assign an         = an_reg;
  assign digit_val  = digit_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a small slot length so whole frames run fast.
// A frame-position model predicts every registered output each cycle.
module tb_seg7_scan_ctrl;

  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        load = 1'b0;
  logic        disp_en = 1'b1;
  logic        blank_lz = 1'b0;
  logic [1:0]  sel;
  logic [3:0]  digit_val;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: k = internal cycles elapsed since reset release.
  int k = 0;
  int m_disp = 0;
  int m_pending = 0;
  bit m_pend = 1'b0;
  logic [3:0] exp_an  = 4'hF;
  logic [1:0] exp_sel = 2'd0;
  logic [3:0] exp_dig = 4'h0;
  logic       exp_fd  = 1'b0;

  seg7_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .disp_en    (disp_en),
    .blank_lz   (blank_lz),
    .sel        (sel),
    .digit_val  (digit_val),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (k=%0d, t=%0t)", name, act, expv, k, $time);
    end
  endtask

  // Model: from the frame position and the current display word, work out
  // what the outputs must show after this edge, then apply buffering rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; m_disp = 0; m_pending = 0; m_pend = 1'b0;
      exp_an = 4'hF; exp_sel = 2'd0; exp_dig = 4'h0; exp_fd = 1'b0;
    end else begin
      int pos, slot, c, lead;
      bit blanked;
      pos  = k % FRAME;
      slot = pos / RD;
      c    = pos % RD;
      lead = m_disp >> (4 * (3 - slot));
      blanked = blank_lz && (slot < 3) && (lead == 0);
      exp_sel = 2'(slot);
      exp_dig = 4'(lead & 15);
      exp_an  = (c >= GC && disp_en && !blanked) ? ~(4'b1000 >> slot) : 4'hF;
      exp_fd  = (pos == 0) && (k >= FRAME);
      if (pos == FRAME - 1) begin
        if (load) begin
          m_disp = int'(data_in); m_pend = 1'b0;
        end else if (m_pend) begin
          m_disp = m_pending; m_pend = 1'b0;
        end
      end else if (load) begin
        m_pending = int'(data_in); m_pend = 1'b1;
      end
      k++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("an", 16'(an), 16'(exp_an));
    check("sel", 16'(sel), 16'(exp_sel));
    check("digit_val", 16'(digit_val), 16'(exp_dig));
    check("frame_done", 16'(frame_done), 16'(exp_fd));
  end

  task automatic wait_k(input int target);
    int guard = 0;
    while (k != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_k: reached k=%0d, required %0d", k, target);
    end
  endtask

  task automatic do_load(input logic [15:0] word);
    $display("load 0x%04h at k=%0d", word, k);
    data_in = word;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] e_an, input logic [3:0] e_dig);
    $display("check %s at k=%0d: an=%b digit_val=%h", name, k, an, digit_val);
    check({name, "_an"}, 16'(an), 16'(e_an));
    check({name, "_dig"}, 16'(digit_val), 16'(e_dig));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic word, pending until the first boundary.
    wait_k(3);   do_load(16'h1234);
    wait_k(33);  lit("f1_start", 4'hF, 4'h1); check("f1_fd", 16'(frame_done), 16'd1);
    wait_k(35);  lit("f1_s0", 4'b0111, 4'h1);
    wait_k(43);  lit("f1_s1", 4'b1011, 4'h2);
    wait_k(65);  check("f2_fd", 16'(frame_done), 16'd1);

    // Two mid-frame loads: the last one wins, the old word holds this frame.
    wait_k(70);  do_load(16'hAAAA);
    wait_k(80);  do_load(16'h5A5A);
    wait_k(83);  lit("f2_s2_old", 4'b1101, 4'h3);
    wait_k(99);  lit("f3_s0", 4'b0111, 4'h5);
    wait_k(107); lit("f3_s1", 4'b1011, 4'hA);

    // Load exactly on the frame boundary.
    wait_k(127); do_load(16'hBEEF);
    wait_k(131); lit("f4_s0", 4'b0111, 4'hB);
    wait_k(187); lit("f5_s3", 4'b1110, 4'hF);

    // Leading-zero blanking.
    wait_k(195); blank_lz = 1'b1; do_load(16'h0050);
    wait_k(227); lit("lz_s0", 4'hF, 4'h0);
    wait_k(243); lit("lz_s2", 4'b1101, 4'h5);
    wait_k(251); lit("lz_s3", 4'b1110, 4'h0);
    wait_k(260); do_load(16'h0000);
    wait_k(307); lit("zero_s2", 4'hF, 4'h0);
    wait_k(315); lit("zero_s3", 4'b1110, 4'h0);

    // Display disabled for a full frame.
    wait_k(320); blank_lz = 1'b0; do_load(16'h1234);
    wait_k(352); disp_en = 1'b0;
    wait_k(360); lit("dis_s0", 4'hF, 4'h1);
    wait_k(384); disp_en = 1'b1;
    wait_k(385); check("dis_fd", 16'(frame_done), 16'd1);
    wait_k(387); lit("reen_s0", 4'b0111, 4'h1);

    // Asynchronous reset in the middle of slot 2.
    wait_k(400);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    $display("async reset at t=%0t: an=%b sel=%0d", $time, an, sel);
    check("rst_an", 16'(an), 16'hF);
    check("rst_sel", 16'(sel), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_k(20); lit("post_rst", 4'b1101, 4'h0); check("post_rst_fd", 16'(frame_done), 16'd0);
    wait_k(31); check("post_rst_fd_early", 16'(frame_done), 16'd0);
    wait_k(33); check("post_rst_fd", 16'(frame_done), 16'd1);
    wait_k(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
